// File: rtl/spi_ram_master_ctrl.sv
// spi_ram_master_ctrl
// Host-side SPI master that turns one write or read request into a complete
// RAM access on the SPI RAM slave: an address frame, an SS_n-high gap, a data
// frame and, for reads, a latency wait followed by eight MISO captures.
//
// Frame shape: 12 SS_n-low cycles f=0..11. MOSI is 0 at f=0,1, then carries
// {cmd[1:0], payload[7:0]} MSB first at f=2..11. SS_n and MOSI are registered.
//
// Handshake: a request transfers on a cycle where cmd_valid && cmd_ready are
// both high. cmd_ready is high only in IDLE (and never during rst); cmd_valid
// is ignored at all other times. Request fields are latched on that cycle.
// rsp_valid is a single-cycle pulse with no back-pressure.
//
// Build option: define SPI_MCTRL_ADDR_CACHE_EN to remember the last address
// sent. A request whose address matches skips the address frame and gap and
// starts its data frame the cycle after accept. Leaving it undefined gives the
// plain controller with no cache registers.
//
// RD_LAT is counted with the 4-bit frame counter, so 1 <= RD_LAT <= 16.
module spi_ram_master_ctrl #(
  parameter int ADDR_SIZE  = 8,
  parameter int GAP_CYCLES = 1,
  parameter int RD_LAT     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_wr,
  input  logic [ADDR_SIZE-1:0] cmd_addr,
  input  logic [7:0]           cmd_wdata,
  output logic                 rsp_valid,
  output logic [7:0]           rsp_rdata,
  output logic                 busy,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO,
  output logic [2:0]           dbg_state
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       FRM_LAST  = 4'd11;
  // Last RD_WAIT count; RD_WAIT is bypassed entirely when RD_LAT == 1.
  localparam logic [3:0]       WAIT_LAST = 4'(RD_LAT - 2);
  localparam logic [2:0]       CAP_LAST  = 3'd7;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR_FRM = 3'd1,
    S_GAP1     = 3'd2,
    S_DATA_FRM = 3'd3,
    S_RD_WAIT  = 3'd4,
    S_RD_CAP   = 3'd5,
    S_GAP2     = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         fcnt_q, fcnt_d;      // frame bit counter, reused for RD_LAT wait
  logic [3:0]         ccnt_q, ccnt_d;      // capture counter, 0..7
  logic [GAP_W-1:0]   gcnt_q, gcnt_d;      // SS_n-high gap counter
  logic               wr_q, wr_d;
  logic [7:0]         addr_q, addr_d;      // zero-extended request address
  logic [7:0]         wdata_q, wdata_d;
  logic [6:0]         shift_q, shift_d;    // first seven captured MISO bits
  logic [7:0]         rsp_rdata_q, rsp_rdata_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               ss_n_q, ss_n_d;
  logic               mosi_q, mosi_d;

  logic [9:0]         frm_word;
  logic [3:0]         bit_idx;
  logic               cache_hit;

`ifdef SPI_MCTRL_ADDR_CACHE_EN
  logic               cache_vld_q, cache_vld_d;
  logic [7:0]         last_addr_q, last_addr_d;

  assign cache_hit = cache_vld_q && (8'(cmd_addr) == last_addr_q);
`else
  assign cache_hit = 1'b0;
`endif

  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign busy      = (state_q != S_IDLE) && !rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;
  assign dbg_state = state_q;

  // Next-state logic: sequences frames, gaps, read wait and capture.
  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    ccnt_d      = ccnt_q;
    gcnt_d      = gcnt_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    shift_d     = shift_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_valid_d = 1'b0;
`ifdef SPI_MCTRL_ADDR_CACHE_EN
    cache_vld_d = cache_vld_q;
    last_addr_d = last_addr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          wr_d    = cmd_wr;
          addr_d  = 8'(cmd_addr);
          wdata_d = cmd_wdata;
          fcnt_d  = 4'd0;
          // A cached address means the slave already holds it: go straight to data.
          state_d = cache_hit ? S_DATA_FRM : S_ADDR_FRM;
        end
      end
      S_ADDR_FRM: begin
        if (fcnt_q == FRM_LAST) begin
          state_d = S_GAP1;
          gcnt_d  = '0;
`ifdef SPI_MCTRL_ADDR_CACHE_EN
          cache_vld_d = 1'b1;
          last_addr_d = addr_q;
`endif
        end else begin
          fcnt_d = fcnt_q + 4'd1;
        end
      end
      S_GAP1: begin
        if (gcnt_q == GAP_LAST) begin
          state_d = S_DATA_FRM;
          fcnt_d  = 4'd0;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      S_DATA_FRM: begin
        if (fcnt_q == FRM_LAST) begin
          fcnt_d = 4'd0;
          ccnt_d = 4'd0;
          gcnt_d = '0;
          if (wr_q) begin
            state_d     = S_GAP2;
            rsp_valid_d = 1'b1;
          end else if (RD_LAT == 1) begin
            state_d = S_RD_CAP;
          end else begin
            state_d = S_RD_WAIT;
          end
        end else begin
          fcnt_d = fcnt_q + 4'd1;
        end
      end
      S_RD_WAIT: begin
        // RD_LAT-1 cycles so that the first capture lands at f=11+RD_LAT.
        if (fcnt_q == WAIT_LAST) begin
          state_d = S_RD_CAP;
        end else begin
          fcnt_d = fcnt_q + 4'd1;
        end
      end
      S_RD_CAP: begin
        shift_d = {shift_q[5:0], MISO};
        if (ccnt_q[2:0] == CAP_LAST) begin
          state_d     = S_GAP2;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = {shift_q, MISO};
        end else begin
          ccnt_d = ccnt_q + 4'd1;
        end
      end
      S_GAP2: begin
        if (gcnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Serialiser: registered SS_n/MOSI values for the state/counter being entered.
  always_comb begin
    frm_word = 10'd0;
    bit_idx  = 4'd0;
    mosi_d   = 1'b0;
    ss_n_d   = 1'b1;
    if (state_d == S_ADDR_FRM) begin
      frm_word = {(wr_d ? CMD_WR_ADDR : CMD_RD_ADDR), addr_d};
    end else begin
      frm_word = {(wr_d ? CMD_WR_DATA : CMD_RD_DATA), (wr_d ? wdata_d : 8'h00)};
    end
    if (state_d == S_ADDR_FRM || state_d == S_DATA_FRM ||
        state_d == S_RD_WAIT  || state_d == S_RD_CAP) begin
      ss_n_d = 1'b0;
    end
    // f=2 carries word bit 9, f=11 carries bit 0; MOSI stays 0 otherwise.
    if ((state_d == S_ADDR_FRM || state_d == S_DATA_FRM) && fcnt_d >= 4'd2) begin
      bit_idx = FRM_LAST - fcnt_d;
      mosi_d  = frm_word[bit_idx];
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fcnt_q      <= 4'd0;
      ccnt_q      <= 4'd0;
      gcnt_q      <= '0;
      wr_q        <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      shift_q     <= 7'h00;
      rsp_rdata_q <= 8'h00;
      rsp_valid_q <= 1'b0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      ccnt_q      <= ccnt_d;
      gcnt_q      <= gcnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      shift_q     <= shift_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_valid_q <= rsp_valid_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
    end
  end

`ifdef SPI_MCTRL_ADDR_CACHE_EN
  // Address cache; reset (including a mid-access abort) invalidates it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_vld_q <= 1'b0;
      last_addr_q <= 8'h00;
    end else begin
      cache_vld_q <= cache_vld_d;
      last_addr_q <= last_addr_d;
    end
  end
`endif

endmodule

// File: tb/tb_spi_ram_master_ctrl.sv
// tb_spi_ram_master_ctrl
// Directed bench for spi_ram_master_ctrl with default parameters. A small SPI
// RAM slave model decodes the MOSI frames into its own memory and returns read
// data on MISO. Every access is checked cycle by cycle against the expected
// SS_n/MOSI/rsp_valid/busy/cmd_ready timeline, using hand-written frame words.
// Honours SPI_MCTRL_ADDR_CACHE_EN: accesses marked as cache hits then expect
// no address frame.
module tb_spi_ram_master_ctrl;

  localparam int RD_LAT = 4;

`ifdef SPI_MCTRL_ADDR_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_wr;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [2:0] dbg_state;

  int n_chk;
  int n_err;

  logic [7:0] mem [256];

  spi_ram_master_ctrl #(
    .ADDR_SIZE (8),
    .GAP_CYCLES(1),
    .RD_LAT    (RD_LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_wr   (cmd_wr),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .busy     (busy),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: counts SS_n-low cycles, decodes frames at f=11 and drives
  // MISO bit 7..0 at f=11+RD_LAT..f=18+RD_LAT of an RD_DATA frame.
  initial begin : slave_model
    int         s_f;
    bit         s_rd;
    logic [9:0] s_sh;
    logic [7:0] s_addr;
    logic [7:0] s_rdat;
    int         idx;
    s_f    = 0;
    s_rd   = 1'b0;
    s_sh   = 10'd0;
    s_addr = 8'h00;
    s_rdat = 8'h00;
    MISO   = 1'b0;
    forever begin
      @(negedge clk);
      if (SS_n !== 1'b0) begin
        s_f  = 0;
        s_rd = 1'b0;
        MISO = 1'b0;
      end else begin
        if (s_f >= 2 && s_f <= 11) s_sh = {s_sh[8:0], MOSI};
        if (s_f == 11) begin
          case (s_sh[9:8])
            2'b00, 2'b10: s_addr = s_sh[7:0];
            2'b01:        mem[s_addr] = s_sh[7:0];
            default: begin
              s_rdat = mem[s_addr];
              s_rd   = 1'b1;
            end
          endcase
        end
        if (s_rd && s_f >= 11 + RD_LAT && s_f <= 18 + RD_LAT) begin
          idx  = 7 - (s_f - 11 - RD_LAT);
          MISO = s_rdat[idx];
        end else begin
          MISO = 1'b0;
        end
        s_f++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One complete access starting in the current (IDLE) cycle A. Cycle n is
  // A+n. hold keeps cmd_valid high and scrambles the fields while busy.
  task automatic run_access(input string tag, input bit wr, input logic [7:0] addr,
                            input logic [7:0] wdata, input logic [9:0] w1,
                            input logic [9:0] w2, input logic [7:0] exp_rdata,
                            input bit hit, input bit hold);
    bit   addr_frm;
    int   base;
    int   last;
    int   f;
    logic exp_ss;
    logic exp_mosi;
    addr_frm  = !(CACHE_EN && hit);
    base      = addr_frm ? 13 : 0;
    last      = wr ? base + 13 : base + 24;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
    chk({tag, " ready_at_A"}, 32'(cmd_ready), 32'd1);
    for (int n = 1; n <= last + 1; n++) begin
      @(negedge clk);
      exp_ss   = 1'b1;
      exp_mosi = 1'b0;
      if (addr_frm && n <= 12) begin
        exp_ss = 1'b0;
        f      = n - 1;
        if (f >= 2) exp_mosi = w1[11 - f];
      end
      if (n >= base + 1 && n <= base + 12) begin
        exp_ss = 1'b0;
        f      = n - base - 1;
        if (f >= 2) exp_mosi = w2[11 - f];
      end
      if (!wr && n >= base + 13 && n <= base + 23) exp_ss = 1'b0;
      chk($sformatf("%s n=%0d ss_n", tag, n), 32'(SS_n), 32'(exp_ss));
      chk($sformatf("%s n=%0d mosi", tag, n), 32'(MOSI), 32'(exp_mosi));
      chk($sformatf("%s n=%0d rsp_valid", tag, n), 32'(rsp_valid), 32'(n == last));
      chk($sformatf("%s n=%0d busy", tag, n), 32'(busy), 32'(n <= last));
      chk($sformatf("%s n=%0d cmd_ready", tag, n), 32'(cmd_ready), 32'(n == last + 1));
      if (!wr && n == last) chk({tag, " rsp_rdata"}, 32'(rsp_rdata), 32'(exp_rdata));
      if (n == 1 && !hold) cmd_valid = 1'b0;
      if (hold && n == 5) begin
        cmd_wr    = !wr;
        cmd_addr  = ~addr;
        cmd_wdata = ~wdata;
      end
    end
  endtask

  // Directed sequence
  initial begin
    n_chk     = 0;
    n_err     = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = 8'h00;
    cmd_wdata = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'hEE;

    // Reset values while rst is high
    repeat (3) @(negedge clk);
    chk("rst ss_n", 32'(SS_n), 32'd1);
    chk("rst mosi", 32'(MOSI), 32'd0);
    chk("rst cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rsp_rdata", 32'(rsp_rdata), 32'h00);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst cmd_ready", 32'(cmd_ready), 32'd1);

    // Test 1: reset for 3 cycles in the middle of a read's data frame
    cmd_wr    = 1'b0;
    cmd_addr  = 8'h3C;
    cmd_wdata = 8'h00;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (17) @(negedge clk);
    chk("abort pre ss_n", 32'(SS_n), 32'd0);
    chk("abort pre busy", 32'(busy), 32'd1);
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("abort rst%0d ss_n", c), 32'(SS_n), 32'd1);
      chk($sformatf("abort rst%0d mosi", c), 32'(MOSI), 32'd0);
      chk($sformatf("abort rst%0d rsp_valid", c), 32'(rsp_valid), 32'd0);
      chk($sformatf("abort rst%0d cmd_ready", c), 32'(cmd_ready), 32'd0);
      chk($sformatf("abort rst%0d busy", c), 32'(busy), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort cmd_ready", 32'(cmd_ready), 32'd1);
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("abort idle%0d rsp_valid", c), 32'(rsp_valid), 32'd0);
      chk($sformatf("abort idle%0d ss_n", c), 32'(SS_n), 32'd1);
      @(negedge clk);
    end

    // Test 2: write 0xA5 to 0x3C
    run_access("wr3C", 1'b1, 8'h3C, 8'hA5, 10'b00_0011_1100, 10'b01_1010_0101, 8'h00, 1'b0, 1'b0);
    chk("mem[3C]", 32'(mem[8'h3C]), 32'hA5);

    // Test 3: read back 0x3C
    run_access("rd3C", 1'b0, 8'h3C, 8'h00, 10'b10_0011_1100, 10'b11_0000_0000, 8'hA5, 1'b1, 1'b0);

    // Test 5: boundary addresses and data patterns
    run_access("wr00", 1'b1, 8'h00, 8'hFF, 10'b00_0000_0000, 10'b01_1111_1111, 8'h00, 1'b0, 1'b0);
    run_access("wrFF", 1'b1, 8'hFF, 8'h80, 10'b00_1111_1111, 10'b01_1000_0000, 8'h00, 1'b0, 1'b0);
    run_access("rd00", 1'b0, 8'h00, 8'h00, 10'b10_0000_0000, 10'b11_0000_0000, 8'hFF, 1'b0, 1'b0);
    run_access("rdFF", 1'b0, 8'hFF, 8'h00, 10'b10_1111_1111, 10'b11_0000_0000, 8'h80, 1'b0, 1'b0);
    run_access("wr80", 1'b1, 8'h80, 8'h00, 10'b00_1000_0000, 10'b01_0000_0000, 8'h00, 1'b0, 1'b0);
    run_access("rd80", 1'b0, 8'h80, 8'h00, 10'b10_1000_0000, 10'b11_0000_0000, 8'h00, 1'b1, 1'b0);
    chk("mem[00]", 32'(mem[8'h00]), 32'hFF);
    chk("mem[FF]", 32'(mem[8'hFF]), 32'h80);
    chk("mem[80]", 32'(mem[8'h80]), 32'h00);

    // Test 4: back-to-back with cmd_valid held and fields scrambled while busy
    run_access("b2b_wr55", 1'b1, 8'h55, 8'h5A, 10'b00_0101_0101, 10'b01_0101_1010, 8'h00, 1'b0, 1'b1);
    run_access("b2b_rd55", 1'b0, 8'h55, 8'h00, 10'b10_0101_0101, 10'b11_0000_0000, 8'h5A, 1'b1, 1'b1);
    run_access("b2b_wr66", 1'b1, 8'h66, 8'h3C, 10'b00_0110_0110, 10'b01_0011_1100, 8'h00, 1'b0, 1'b0);
    chk("mem[66]", 32'(mem[8'h66]), 32'h3C);
    chk("mem[AA]", 32'(mem[8'hAA]), 32'hEE);

    // Test 6: address-cache sequence (two frames everywhere when disabled)
    run_access("wr11", 1'b1, 8'h11, 8'h96, 10'b00_0001_0001, 10'b01_1001_0110, 8'h00, 1'b0, 1'b0);
    run_access("wr10", 1'b1, 8'h10, 8'hC3, 10'b00_0001_0000, 10'b01_1100_0011, 8'h00, 1'b0, 1'b0);
    run_access("rd10", 1'b0, 8'h10, 8'h00, 10'b10_0001_0000, 10'b11_0000_0000, 8'hC3, 1'b1, 1'b0);
    run_access("rd11", 1'b0, 8'h11, 8'h00, 10'b10_0001_0001, 10'b11_0000_0000, 8'h96, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_rst rsp_rdata", 32'(rsp_rdata), 32'h00);
    chk("idle_rst cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rst cmd_ready_after", 32'(cmd_ready), 32'd1);
    run_access("rd11_after_rst", 1'b0, 8'h11, 8'h00, 10'b10_0001_0001, 10'b11_0000_0000, 8'h96, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
